// File: rtl/truth_sweep_if.sv
// Handshake/bus bundle between a sweep controller (master) and truth_sweep_engine (slave).
interface truth_sweep_if #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 3,
  parameter int unsigned SIG_W = 8
) ();
  logic             start;
  logic             pause;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] resp;
  logic [N_IN-1:0]  step_idx;
  logic             cap_valid;
  logic [N_IN-1:0]  cap_vec;
  logic [N_OUT-1:0] cap_resp;
  logic [SIG_W-1:0] signature;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, resp,
    input  vec, step_idx, cap_valid, cap_vec, cap_resp, signature, busy, done
  );

  modport slave (
    input  start, pause, resp,
    output vec, step_idx, cap_valid, cap_vec, cap_resp, signature, busy, done
  );
endinterface

// File: rtl/truth_sweep_engine.sv
// Sweeps all 2^N_IN vectors into a combinational block, dwelling DWELL cycles each,
// and folds the sampled responses into a Galois MISR. Define GRAY_ORDER_EN for Gray-ordered vectors.
module truth_sweep_engine #(
  parameter int unsigned      N_IN  = 3,
  parameter int unsigned      N_OUT = 3,
  parameter int unsigned      DWELL = 10,
  parameter int unsigned      SIG_W = 8,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(8'h1D)
) (
  input logic         clk,
  input logic         rst,
  truth_sweep_if.slave bus
);

  localparam int unsigned     CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [N_IN-1:0]  IDX_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;

  // Index-to-vector ordering; step_idx itself always counts in binary.
  function automatic logic [N_IN-1:0] map_idx(input logic [N_IN-1:0] idx);
`ifdef GRAY_ORDER_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [N_OUT-1:0] r);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(r);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      dwell_cnt     <= '0;
      bus.vec       <= '0;
      bus.step_idx  <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_vec   <= '0;
      bus.cap_resp  <= '0;
      bus.signature <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.cap_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state         <= S_DRIVE;
            dwell_cnt     <= '0;
            bus.step_idx  <= '0;
            bus.vec       <= map_idx('0);
            bus.signature <= '0;
            bus.busy      <= 1'b1;
            bus.done      <= 1'b0;
          end
        end
        S_DRIVE: begin
          // pause freezes everything; a sample due on a paused edge slips to the next unpaused one
          if (!bus.pause) begin
            if (dwell_cnt == CNT_LAST) begin
              bus.cap_valid <= 1'b1;
              bus.cap_vec   <= bus.vec;
              bus.cap_resp  <= bus.resp;
              bus.signature <= misr_next(bus.signature, bus.resp);
              dwell_cnt     <= '0;
              if (bus.step_idx != IDX_LAST) begin
                bus.step_idx <= bus.step_idx + N_IN'(1);
                bus.vec      <= map_idx(bus.step_idx + N_IN'(1));
              end else begin
                state    <= S_DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
